// File: rtl/even_pipe_issue_ctrl.sv
// Even-pipe issue controller: scoreboard of in-flight destinations, RAW stall
// generation and a saturating stall-cycle counter.
module even_pipe_issue_ctrl #(
  parameter int DEPTH = 7,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_unit_id,
  input  logic [6:0]       in_reg_dst,
  input  logic             in_reg_wr,
  input  logic [3:0]       in_latency,
  input  logic [6:0]       in_ra_addr,
  input  logic [6:0]       in_rb_addr,
  input  logic [6:0]       in_rc_addr,
  input  logic             in_ra_use,
  input  logic             in_rb_use,
  input  logic             in_rc_use,
  output logic             pipe_valid,
  output logic             pipe_reg_wr,
  output logic             illegal_unit,
  output logic             stall_raw,
  output logic [CNT_W-1:0] stall_cnt
);

  logic             r_sb_v   [1:DEPTH];
  logic [6:0]       r_sb_dst [1:DEPTH];
  logic [3:0]       r_sb_lat [1:DEPTH];
  logic [CNT_W-1:0] r_stall_cnt;

  logic             w_live   [1:DEPTH];
  logic             w_hazard;
  logic             w_fire;
  logic             w_legal;

  function automatic logic [3:0] eff_lat(input logic [3:0] lat);
    if (lat == 4'd0) return 4'd1;
    if (int'(lat) > DEPTH) return 4'(DEPTH);
    return lat;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // An entry blocks only while its result is not yet forwardable (stage < latency).
  for (genvar k = 1; k <= DEPTH; k++) begin : g_live
    assign w_live[k] = r_sb_v[k] && (4'(k) < r_sb_lat[k]);
  end

  always_comb begin
    w_hazard = 1'b0;
    for (int k = 1; k <= DEPTH; k++) begin
      if (w_live[k] &&
          ((in_ra_use && r_sb_dst[k] == in_ra_addr) ||
           (in_rb_use && r_sb_dst[k] == in_rb_addr) ||
           (in_rc_use && r_sb_dst[k] == in_rc_addr)))
        w_hazard = 1'b1;
    end
  end

  assign w_legal      = (in_unit_id <= 3'd3);
  assign in_ready     = !rst && !w_hazard;
  assign w_fire       = in_valid && in_ready;
  assign pipe_valid   = w_fire;
  assign pipe_reg_wr  = w_fire && in_reg_wr && w_legal;
  assign illegal_unit = w_fire && !w_legal;
  assign stall_raw    = !rst && in_valid && w_hazard;
  assign stall_cnt    = r_stall_cnt;

  // Stage boundary: issue -> sb[1], sb[k] -> sb[k+1]; control state is reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 1; k <= DEPTH; k++) r_sb_v[k] <= 1'b0;
      r_stall_cnt <= '0;
    end else begin
      r_sb_v[1] <= pipe_reg_wr;
      for (int k = 2; k <= DEPTH; k++) r_sb_v[k] <= r_sb_v[k-1];
      if (stall_raw) r_stall_cnt <= sat_inc(r_stall_cnt);
    end
  end

  always_ff @(posedge clk) begin
    r_sb_dst[1] <= in_reg_dst;
    r_sb_lat[1] <= eff_lat(in_latency);
    for (int k = 2; k <= DEPTH; k++) begin
      r_sb_dst[k] <= r_sb_dst[k-1];
      r_sb_lat[k] <= r_sb_lat[k-1];
    end
  end

endmodule

// File: tb/tb_even_pipe_issue_ctrl.sv
// Bench for even_pipe_issue_ctrl: directed scenarios plus random traffic
// checked against a per-register "result ready at cycle" model.
module tb_even_pipe_issue_ctrl;

  localparam int DEPTH = 7;
  localparam int CNT_W = 4;
  localparam int MAXC  = (1 << CNT_W) - 1;

  typedef struct packed {
    logic       vld;
    logic [2:0] unit;
    logic [6:0] dst;
    logic       wr;
    logic [3:0] lat;
    logic [6:0] ra, rb, rc;
    logic       ua, ub, uc;
  } ins_t;

  logic clk = 1'b0;
  logic rst;
  logic in_valid, in_ready, in_reg_wr;
  logic [2:0] in_unit_id;
  logic [6:0] in_reg_dst, in_ra_addr, in_rb_addr, in_rc_addr;
  logic [3:0] in_latency;
  logic in_ra_use, in_rb_use, in_rc_use;
  logic pipe_valid, pipe_reg_wr, illegal_unit, stall_raw;
  logic [CNT_W-1:0] stall_cnt;

  int n_checks = 0;
  int n_errors = 0;

  // Model: cycle at which each register's newest pending result is forwardable.
  int ready_at [128];
  int cyc   = 0;
  int m_cnt = 0;

  logic obs_ready, obs_wr, obs_ill;

  always #5 clk = ~clk;

  even_pipe_issue_ctrl #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_unit_id(in_unit_id), .in_reg_dst(in_reg_dst), .in_reg_wr(in_reg_wr),
    .in_latency(in_latency),
    .in_ra_addr(in_ra_addr), .in_rb_addr(in_rb_addr), .in_rc_addr(in_rc_addr),
    .in_ra_use(in_ra_use), .in_rb_use(in_rb_use), .in_rc_use(in_rc_use),
    .pipe_valid(pipe_valid), .pipe_reg_wr(pipe_reg_wr),
    .illegal_unit(illegal_unit), .stall_raw(stall_raw), .stall_cnt(stall_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic int leff(input logic [3:0] lat);
    if (lat == 0) return 1;
    if (lat > DEPTH) return DEPTH;
    return int'(lat);
  endfunction

  // One clock cycle: drive, check combinational outputs and counter, advance model.
  task automatic step(input logic r, input ins_t x);
    logic haz, e_ready, e_fire, e_legal, e_wr, e_ill, e_stall;
    @(negedge clk);
    rst = r; in_valid = x.vld; in_unit_id = x.unit; in_reg_dst = x.dst;
    in_reg_wr = x.wr; in_latency = x.lat;
    in_ra_addr = x.ra; in_rb_addr = x.rb; in_rc_addr = x.rc;
    in_ra_use = x.ua; in_rb_use = x.ub; in_rc_use = x.uc;
    #1;
    haz = (x.ua && cyc < ready_at[x.ra]) || (x.ub && cyc < ready_at[x.rb]) ||
          (x.uc && cyc < ready_at[x.rc]);
    e_ready = !r && !haz;
    e_fire  = x.vld && e_ready;
    e_legal = (x.unit <= 3);
    e_wr    = e_fire && x.wr && e_legal;
    e_ill   = e_fire && !e_legal;
    e_stall = !r && x.vld && haz;
    chk("in_ready", in_ready, e_ready);
    chk("pipe_valid", pipe_valid, e_fire);
    chk("pipe_reg_wr", pipe_reg_wr, e_wr);
    chk("illegal_unit", illegal_unit, e_ill);
    chk("stall_raw", stall_raw, e_stall);
    chk("stall_cnt", stall_cnt, m_cnt);
    obs_ready = in_ready; obs_wr = pipe_reg_wr; obs_ill = illegal_unit;
    @(posedge clk);
    if (r) begin
      for (int i = 0; i < 128; i++) ready_at[i] = 0;
      m_cnt = 0;
    end else begin
      if (e_wr && cyc + leff(x.lat) > ready_at[x.dst]) ready_at[x.dst] = cyc + leff(x.lat);
      if (e_stall && m_cnt < MAXC) m_cnt++;
    end
    cyc++;
  endtask

  task automatic hold_until_fire(input string tag, input ins_t x, output int stalls);
    logic fired = 1'b0;
    stalls = 0;
    for (int i = 0; i < 40 && !fired; i++) begin
      step(1'b0, x);
      if (obs_ready) fired = 1'b1;
      else stalls++;
    end
    chk({tag, "_fired"}, fired, 1'b1);
  endtask

  function automatic ins_t mk(input logic [2:0] unit, input logic [6:0] dst, input logic wr,
                              input logic [3:0] lat);
    ins_t t = '0;
    t.vld = 1'b1; t.unit = unit; t.dst = dst; t.wr = wr; t.lat = lat;
    return t;
  endfunction

  function automatic ins_t rd(input logic [6:0] a, input logic [6:0] b, input logic [6:0] c,
                              input logic ua, input logic ub, input logic uc);
    ins_t t = '0;
    t.vld = 1'b1; t.dst = 7'd100; t.wr = 1'b1; t.lat = 4'd1;
    t.ra = a; t.rb = b; t.rc = c; t.ua = ua; t.ub = ub; t.uc = uc;
    return t;
  endfunction

  ins_t idle = '0;
  ins_t ri;
  int   ns;

  initial begin
    for (int i = 0; i < 128; i++) ready_at[i] = 0;
    rst = 1'b1; in_valid = 1'b0; in_unit_id = '0; in_reg_dst = '0; in_reg_wr = 1'b0;
    in_latency = '0; in_ra_addr = '0; in_rb_addr = '0; in_rc_addr = '0;
    in_ra_use = 1'b0; in_rb_use = 1'b0; in_rc_use = 1'b0;
    repeat (2) @(posedge clk);

    // Reset state with a valid request present.
    step(1'b1, rd(7'd1, 7'd2, 7'd3, 1'b1, 1'b1, 1'b1));
    step(1'b1, idle);

    // Latency-6 producer, dependent reader via ra.
    step(1'b0, mk(3'd0, 7'd10, 1'b1, 4'd6));
    hold_until_fire("lat6", rd(7'd10, 7'd0, 7'd0, 1'b1, 1'b0, 1'b0), ns);
    chk("lat6_stalls", ns, 5);
    step(1'b0, idle);
    chk("lat6_cnt", stall_cnt, 5);

    // Latency 2 via rc, then the same with rc unused.
    step(1'b0, mk(3'd1, 7'd3, 1'b1, 4'd2));
    hold_until_fire("lat2", rd(7'd0, 7'd0, 7'd3, 1'b0, 1'b0, 1'b1), ns);
    chk("lat2_stalls", ns, 1);
    step(1'b0, mk(3'd1, 7'd3, 1'b1, 4'd2));
    hold_until_fire("lat2_unused", rd(7'd0, 7'd0, 7'd3, 1'b0, 1'b0, 1'b0), ns);
    chk("lat2_unused_stalls", ns, 0);

    // Non-writing producer.
    step(1'b0, mk(3'd2, 7'd5, 1'b0, 4'd7));
    chk("nowr_pipe_reg_wr", obs_wr, 1'b0);
    hold_until_fire("nowr", rd(7'd5, 7'd5, 7'd5, 1'b1, 1'b1, 1'b1), ns);
    chk("nowr_stalls", ns, 0);

    // Illegal unit.
    step(1'b0, mk(3'd5, 7'd20, 1'b1, 4'd7));
    chk("illegal_pulse", obs_ill, 1'b1);
    chk("illegal_reg_wr", obs_wr, 1'b0);
    hold_until_fire("illegal", rd(7'd20, 7'd0, 7'd0, 1'b1, 1'b0, 1'b0), ns);
    chk("illegal_stalls", ns, 0);
    chk("illegal_pulse_gone", obs_ill, 1'b0);

    // Reset in the middle of a stall.
    step(1'b1, idle);
    step(1'b0, mk(3'd3, 7'd30, 1'b1, 4'd7));
    ri = rd(7'd0, 7'd30, 7'd0, 1'b0, 1'b1, 1'b0);
    step(1'b0, ri);
    chk("rst_mid_stalled1", obs_ready, 1'b0);
    step(1'b0, ri);
    step(1'b1, ri);
    step(1'b0, ri);
    chk("rst_mid_fires", obs_ready, 1'b1);
    chk("rst_mid_cnt", stall_cnt, 0);

    // Counter saturation over repeated latency-7 hazards.
    step(1'b1, idle);
    for (int r = 0; r < 4; r++) begin
      step(1'b0, mk(3'd0, 7'd40, 1'b1, 4'd7));
      hold_until_fire("sat", rd(7'd40, 7'd0, 7'd0, 1'b1, 1'b0, 1'b0), ns);
    end
    step(1'b0, idle);
    chk("sat_cnt", stall_cnt, MAXC);

    // Random traffic on a small register file.
    step(1'b1, idle);
    for (int i = 0; i < 500; i++) begin
      ri.vld  = ($urandom_range(3) != 0);
      ri.unit = ($urandom_range(9) == 0) ? 3'($urandom_range(7, 4)) : 3'($urandom_range(3));
      ri.dst  = 7'($urandom_range(7));
      ri.wr   = ($urandom_range(4) != 0);
      ri.lat  = 4'($urandom_range(15));
      ri.ra   = 7'($urandom_range(7));
      ri.rb   = 7'($urandom_range(7));
      ri.rc   = 7'($urandom_range(7));
      ri.ua   = 1'($urandom_range(1));
      ri.ub   = 1'($urandom_range(1));
      ri.uc   = 1'($urandom_range(1));
      step(($urandom_range(59) == 0), ri);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
